// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake between a requester and the PS/2 host transmitter.
//   tx_data  : byte to send, sampled when tx_valid && tx_ready
//   tx_valid : request to send tx_data
//   tx_ready : transmitter idle and able to accept
//   tx_done  : one-cycle pulse when a transfer ends (success or failure)
//   tx_err   : one-cycle pulse alongside tx_done on NACK or timeout
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_err;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_done,
        input  tx_err
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_done,
        output tx_err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Inhibits the bus, issues a request-to-send,
// shifts out start, 8 data bits LSB-first, odd parity and stop on the device's
// clock falls, then samples the device ACK and reports done/error.
//   VGA_clk    : system clock, all state on rising edge
//   rst_n      : asynchronous active-low reset
//   bus        : tx_data/tx_valid/tx_ready/tx_done/tx_err handshake (slave side)
//   KB_clk     : PS/2 clock pad input (asynchronous)
//   KB_data    : PS/2 data pad input (asynchronous)
//   KB_clk_oe  : 1 = pull KB_clk low
//   KB_data_oe : 1 = pull KB_data low
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 2600,
    parameter int unsigned TIMEOUT_CYCLES = 503500
) (
    input  logic           VGA_clk,
    input  logic           rst_n,
    ps2_host_tx_if.slave   bus,
    input  logic           KB_clk,
    input  logic           KB_data,
    output logic           KB_clk_oe,
    output logic           KB_data_oe
);

    localparam int unsigned INH_W      = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TO_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned FRAME_BITS = 10;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t                  state;
    logic [FRAME_BITS-1:0]   frame;
    logic [CNT_W-1:0]        bit_cnt;
    logic [INH_W-1:0]        inh_cnt;
    logic [TO_W-1:0]         to_cnt;
    logic                    nack;
    logic                    tx_ready_q;
    logic                    tx_done_q;
    logic                    tx_err_q;

    // Pad synchronizers; clk_s3 is the edge register. Reset high so that
    // leaving reset on an idle bus never produces a false fall.
    logic clk_s1, clk_s2, clk_s3;
    logic data_s1, data_s2;

    always_ff @(posedge VGA_clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            clk_s3  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= KB_clk;
            clk_s2  <= clk_s1;
            clk_s3  <= clk_s2;
            data_s1 <= KB_data;
            data_s2 <= data_s1;
        end
    end

    logic fall_c;
    logic to_hit_c;
    logic inh_last_c;

    assign fall_c     = clk_s3 & ~clk_s2;
    assign to_hit_c   = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign inh_last_c = (inh_cnt == INH_W'(INHIBIT_CYCLES - 1));

    // Transfer sequencer; every output is a register written here.
    always_ff @(posedge VGA_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            frame      <= '0;
            bit_cnt    <= '0;
            inh_cnt    <= '0;
            to_cnt     <= '0;
            nack       <= 1'b0;
            KB_clk_oe  <= 1'b0;
            KB_data_oe <= 1'b0;
            tx_ready_q <= 1'b1;
            tx_done_q  <= 1'b0;
            tx_err_q   <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            tx_err_q  <= 1'b0;

            case (state)
                IDLE: begin
                    KB_clk_oe  <= 1'b0;
                    KB_data_oe <= 1'b0;
                    // tx_ready comes back one cycle after tx_done
                    tx_ready_q <= 1'b1;
                    if (bus.tx_valid && tx_ready_q) begin
                        frame      <= {1'b1, ~^bus.tx_data, bus.tx_data};
                        inh_cnt    <= '0;
                        tx_ready_q <= 1'b0;
                        KB_clk_oe  <= 1'b1;
                        state      <= INHIBIT;
                    end
                end

                INHIBIT: begin
                    if (inh_last_c) begin
                        KB_data_oe <= 1'b1;
                        state      <= REQ;
                    end else begin
                        inh_cnt <= inh_cnt + INH_W'(1);
                    end
                end

                REQ: begin
                    // release clock with data held low: request-to-send
                    KB_clk_oe <= 1'b0;
                    bit_cnt   <= '0;
                    to_cnt    <= '0;
                    state     <= SHIFT;
                end

                SHIFT: begin
                    if (fall_c) begin
                        to_cnt     <= '0;
                        KB_data_oe <= ~frame[bit_cnt];
                        bit_cnt    <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                            state <= ACK;
                        end
                    end else if (to_hit_c) begin
                        KB_clk_oe  <= 1'b0;
                        KB_data_oe <= 1'b0;
                        tx_done_q  <= 1'b1;
                        tx_err_q   <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                ACK: begin
                    KB_data_oe <= 1'b0;
                    if (fall_c) begin
                        to_cnt <= '0;
                        nack   <= data_s2;
                        state  <= WAIT_IDLE;
                    end else if (to_hit_c) begin
                        KB_clk_oe <= 1'b0;
                        tx_done_q <= 1'b1;
                        tx_err_q  <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                WAIT_IDLE: begin
                    if (clk_s2 && data_s2) begin
                        tx_done_q <= 1'b1;
                        tx_err_q  <= nack;
                        state     <= IDLE;
                    end else if (fall_c) begin
                        to_cnt <= '0;
                    end else if (to_hit_c) begin
                        KB_clk_oe  <= 1'b0;
                        KB_data_oe <= 1'b0;
                        tx_done_q  <= 1'b1;
                        tx_err_q   <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                default: begin
                    KB_clk_oe  <= 1'b0;
                    KB_data_oe <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_ready = tx_ready_q;
    assign bus.tx_done  = tx_done_q;
    assign bus.tx_err   = tx_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain pad model plus a PS/2 device model that
// clocks at 40 VGA_clk periods, records the bits it reads and ACKs or NACKs.
module tb_ps2_host_tx;

    localparam int unsigned INH = 20;
    localparam int unsigned TO  = 400;

    logic VGA_clk = 1'b0;
    logic rst_n   = 1'b0;
    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;
    logic KB_clk, KB_data, KB_clk_oe, KB_data_oe;

    ps2_host_tx_if bus ();

    assign KB_clk  = dev_clk  & ~KB_clk_oe;
    assign KB_data = dev_data & ~KB_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .VGA_clk    (VGA_clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .KB_clk     (KB_clk),
        .KB_data    (KB_data),
        .KB_clk_oe  (KB_clk_oe),
        .KB_data_oe (KB_data_oe)
    );

    always #5 VGA_clk = ~VGA_clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [9:0] frame;
        logic       err;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [7:0] data;
        bit         nack;
        bit         parity;
        bit         err;
    } vec_t;
    vec_t vecs[4];

    // Monitor: length of each KB_clk_oe pulse, position of KB_data_oe rise, done count
    int run_len = 0, data_pos = 0, last_run = 0, last_data_pos = 0, done_cnt = 0;

    always begin
        @(posedge VGA_clk);
        #1;
        if (KB_clk_oe) begin
            run_len = run_len + 1;
            if (KB_data_oe && data_pos == 0) data_pos = run_len;
        end else if (run_len != 0) begin
            last_run      = run_len;
            last_data_pos = data_pos;
            run_len       = 0;
            data_pos      = 0;
        end
        if (bus.tx_done) done_cnt = done_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge VGA_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired, required DUT event", name);
    endtask

    // Holds tx_valid until the DUT accepts; a wait is expected only in the tx_done cycle
    task automatic send(input logic [7:0] d);
        bit rdy;
        int waits;
        waits = 0;
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        do begin
            rdy = bus.tx_ready;
            tick();
            if (!rdy) begin
                waits++;
                if (waits == 1) begin
                    check("no_accept_while_busy", KB_clk_oe, 0);
                    check("ready_after_done", bus.tx_ready, 1);
                end
            end
        end while (!rdy && waits < 10);
        bus.tx_valid = 1'b0;
        if (!rdy) bound_fail("send_accept");
        check("clk_oe_one_cycle_after_accept", KB_clk_oe, 1);
    endtask

    task automatic device(input bit nack, input int n_falls, output logic [9:0] bits);
        int t;
        bits = '0;
        t = 0;
        while (!(KB_clk_oe && KB_data_oe) && t < 3000) begin tick(); t++; end
        if (t >= 3000) begin bound_fail("dev_wait_req"); return; end
        t = 0;
        while (KB_clk_oe && t < 100) begin tick(); t++; end
        repeat (10) tick();
        for (int i = 1; i <= n_falls; i++) begin
            if (i == 11) begin
                dev_data = nack;
                repeat (5) tick();
            end
            dev_clk = 1'b0;
            repeat (20) tick();
            if (i <= 10) bits[i-1] = KB_data;
            dev_clk = 1'b1;
            if (i == 11) dev_data = 1'b1;
            if (i < n_falls) repeat (20) tick();
        end
    endtask

    task automatic wait_done(output bit got, output bit err);
        got = 1'b0;
        err = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            tick();
            if (bus.tx_done) begin
                got = 1'b1;
                err = bus.tx_err;
                check("ready_low_at_done", bus.tx_ready, 0);
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [9:0] bits;
        bit         got, err;
        exp_t       e;
        exp_q.push_back('{frame: {1'b1, v.parity, v.data}, err: v.err});
        fork
            send(v.data);
            device(v.nack, 11, bits);
            wait_done(got, err);
        join
        if (!got) bound_fail($sformatf("done_%02h", v.data));
        e = exp_q.pop_front();
        check($sformatf("frame_%02h", v.data), 32'(bits), 32'(e.frame));
        check($sformatf("err_%02h", v.data), 32'(err), 32'(e.err));
        check("clk_oe_width", last_run, INH + 1);
        check("data_oe_rise_pos", last_data_pos, INH + 1);
        check("clk_released", KB_clk_oe, 0);
        check("data_released", KB_data_oe, 0);
    endtask

    initial begin
        logic [9:0] bits;
        bit         got, err;
        int         d0, t, cnt;

        vecs[0] = '{data: 8'hED, nack: 1'b0, parity: 1'b1, err: 1'b0};
        vecs[1] = '{data: 8'h00, nack: 1'b0, parity: 1'b1, err: 1'b0};
        vecs[2] = '{data: 8'h01, nack: 1'b0, parity: 1'b0, err: 1'b0};
        vecs[3] = '{data: 8'hFF, nack: 1'b1, parity: 1'b1, err: 1'b1};

        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (3) tick();
        check("rst_tx_ready", bus.tx_ready, 1);
        check("rst_clk_oe", KB_clk_oe, 0);
        check("rst_data_oe", KB_data_oe, 0);
        check("rst_tx_done", bus.tx_done, 0);
        check("rst_tx_err", bus.tx_err, 0);
        rst_n = 1'b1;
        repeat (5) tick();

        // ED, then 00 and 01 back-to-back (requests raised in the tx_done cycle), then FF NACKed
        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // tx_valid toggled with 0x55 during a 0xF4 transfer
        repeat (5) tick();
        d0 = done_cnt;
        exp_q.push_back('{frame: {1'b1, 1'b0, 8'hF4}, err: 1'b0});
        fork
            begin
                send(8'hF4);
                for (int k = 0; k < 300; k++) begin
                    bus.tx_data  = 8'h55;
                    bus.tx_valid = ~bus.tx_valid;
                    tick();
                end
                bus.tx_valid = 1'b0;
            end
            device(1'b0, 11, bits);
            wait_done(got, err);
        join
        begin
            exp_t e;
            e = exp_q.pop_front();
            check("toggle_frame_f4", 32'(bits), 32'(e.frame));
            check("toggle_err", 32'(err), 32'(e.err));
        end
        repeat (100) tick();
        check("toggle_single_done", done_cnt - d0, 1);

        // Device never clocks: timeout 400 cycles after SHIFT entry
        send(8'h12);
        t = 0;
        while (KB_clk_oe && t < 100) begin tick(); t++; end
        cnt = 0;
        while (!bus.tx_done && cnt < 1000) begin tick(); cnt++; end
        check("timeout_cycles", cnt, TO);
        check("timeout_err", bus.tx_err, 1);
        check("timeout_clk_oe", KB_clk_oe, 0);
        check("timeout_data_oe", KB_data_oe, 0);
        tick();
        check("timeout_ready", bus.tx_ready, 1);
        repeat (5) tick();

        // Reset after fall 5 of 0xAA
        fork
            send(8'hAA);
            device(1'b0, 5, bits);
        join
        repeat (3) tick();
        check("abort_bits_0_3", 32'(bits[3:0]), 32'h0000000A);
        check("abort_pre_data_oe", KB_data_oe, 1);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        check("abort_clk_oe_async", KB_clk_oe, 0);
        check("abort_data_oe_async", KB_data_oe, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (500) tick();
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_ready", bus.tx_ready, 1);
        run_vec('{data: 8'hAA, nack: 1'b0, parity: 1'b1, err: 1'b0});

        check("scoreboard_empty", exp_q.size(), 0);
        repeat (5) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard over the same KB_clk/KB_data open-drain lines read by the keyboard receiver. The block performs the clock-inhibit request, then shifts out the start bit, 8 data bits LSB-first, odd parity and stop bit on device-generated clock edges. It also samples the device ACK and reports done or error. It sits beside the receiver; pad tristates are driven from the *_oe outputs at top level.

## Interface
- INHIBIT_CYCLES, 2600: VGA_clk cycles KB_clk is held low before the request (≥100 µs at 25.175 MHz).
- TIMEOUT_CYCLES, 503500: maximum VGA_clk cycles allowed between consecutive device clock falling edges (~20 ms); also bounds the wait for line idle.
- VGA_clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- tx_data  in  8  byte to send; captured when tx_valid && tx_ready.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  high only in IDLE.
- KB_clk  in  1  PS/2 clock pad input (asynchronous).
- KB_data  in  1  PS/2 data pad input (asynchronous).
- KB_clk_oe  out  1  1 = pull KB_clk low; 0 = release.
- KB_data_oe  out  1  1 = pull KB_data low; 0 = release.
- tx_done  out  1  one-cycle pulse when a transfer ends (success or failure).
- tx_err  out  1  one-cycle pulse coincident with tx_done on NACK or timeout.

## Operation
- KB_clk and KB_data pass through 2-flop synchronizers; falling edge of KB_clk = previous synced 1 and current synced 0 (one-cycle strobe `fall`).
- Frame register frame[9:0] = {1'b1 stop, ~^tx_data odd parity, tx_data[7:0]}, loaded at accept; bit counter 0..10.
- States:
  - IDLE: both oe = 0; tx_ready = 1; on tx_valid, latch frame, go INHIBIT.
  - INHIBIT: KB_clk_oe = 1 for INHIBIT_CYCLES cycles, then REQ.
  - REQ: KB_clk_oe = 1, KB_data_oe = 1 (start bit 0) for exactly 1 cycle, then SHIFT with KB_clk_oe = 0.
  - SHIFT: KB_data_oe holds start value; on each `fall`, KB_data_oe = ~frame[cnt], cnt++. Falls 1–8 present data bits 0–7, fall 9 parity, fall 10 stop (oe = 0). After fall 10, go ACK.
  - ACK: KB_data_oe = 0; on next `fall` sample synced KB_data: 0 = ACK, 1 = NACK (latched). Go WAIT_IDLE.
  - WAIT_IDLE: when synced KB_clk and KB_data are both 1, pulse tx_done (tx_err = NACK), go IDLE.
- Timeout: counter cleared on entry to SHIFT and on every `fall`; in SHIFT, ACK or WAIT_IDLE, reaching TIMEOUT_CYCLES releases both lines, pulses tx_done and tx_err, and goes to IDLE.
- tx_valid outside IDLE is ignored; tx_data is not resampled mid-transfer.

## Timing
- Reset values: state IDLE, KB_clk_oe = 0, KB_data_oe = 0, tx_ready = 1, tx_done = 0, tx_err = 0, counters 0.
- Accept to KB_clk_oe = 1: 1 cycle (registered outputs).
- KB_clk_oe high for INHIBIT_CYCLES + 1 cycles total; KB_data_oe rises in the last of those cycles.
- Pad fall to KB_data_oe update: 3 VGA_clk cycles (2 sync + edge register); this is well inside the device's half-period.
- tx_done/tx_err: single cycle, registered; tx_ready returns the cycle after tx_done.
- tx_valid and tx_done in the same cycle: the new request is not accepted until tx_ready = 1.
- A `fall` and a timeout in the same cycle: the `fall` wins and the counter clears.
- rst_n asserted at any point releases both lines immediately, asynchronously. After reset, no pulse is emitted for the aborted transfer.
- Spurious `fall` during INHIBIT/REQ (lines are host-driven) is ignored.

## Test plan
Benches use INHIBIT_CYCLES = 20 and TIMEOUT_CYCLES = 400. The device model clocks at period 40 cycles and ACKs.
- Send 0xED -> KB_clk_oe high 21 cycles; data on falls 1–10 = 1,0,1,1,0,1,1,1, parity 1, stop 1; ACK 0 -> tx_done = 1, tx_err = 0.
- Send 0x00, then 0x01 back-to-back -> parity 1 then 0. The second transfer is accepted only after tx_ready returns.
- Model drives NACK (KB_data = 1 at fall 11) on 0xFF -> tx_done = 1, tx_err = 1, lines released.
- Model never clocks after REQ -> 400 cycles after SHIFT entry: tx_done = tx_err = 1, both oe = 0, tx_ready = 1.
- rst_n low after fall 5 of 0xAA -> both oe = 0 in same cycle, no tx_done. A new send of 0xAA after reset completes correctly.
- tx_valid toggled with tx_data = 0x55 during a 0xF4 transfer -> frame bits remain 0xF4's, exactly one tx_done.
